// File: rtl/jrb8_mem_pkg.sv
// rtl/jrb8_mem_pkg.sv - shared types and byte-lane helpers for the QSPI memory bridge
// Purpose: bridge FSM state encoding, QSPI word geometry and byte-lane select/merge.
// Lane k of a word sits at word[31-8k -: 8]; lane 0 is the MSB byte (sent first).
package jrb8_mem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_MERGE,
        S_WR_ISSUE,
        S_WR_WAIT,
        S_RESPOND
    } bridge_state_t;

    localparam int QSPI_WORD_BYTES = 4;

    function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] off,
                                               input logic [7:0] b_in);
        logic [31:0] w;
        w = word;
        case (off)
            2'd0:    w[31:24] = b_in;
            2'd1:    w[23:16] = b_in;
            2'd2:    w[15:8]  = b_in;
            default: w[7:0]   = b_in;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/qspi_line_buffer.sv
// rtl/qspi_line_buffer.sv - one-word line buffer with tag, valid, lane merge and flush
// Purpose: holds the last QSPI word touched by the bridge.
// Ports: clk/rst (async, active-high); i_tag word address of current request;
//   i_flush invalidate pulse; i_idle / i_end bridge in IDLE / RESPOND;
//   i_load + i_load_data fill from controller; i_merge + i_off + i_wbyte byte update;
//   o_hit tag match (forced low by same-cycle flush); o_data line contents.
import jrb8_mem_pkg::*;

module qspi_line_buffer #(
    parameter int TAG_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    input  logic             i_idle,
    input  logic             i_end,
    input  logic             i_load,
    input  logic [31:0]      i_load_data,
    input  logic             i_merge,
    input  logic [1:0]       i_off,
    input  logic [7:0]       i_wbyte,
    output logic             o_hit,
    output logic [31:0]      o_data
);

    logic [TAG_W-1:0] r_tag;
    logic             r_valid;
    logic [31:0]      r_data;
    // Flush seen while a transaction is in flight; applied when it responds.
    logic             r_flush_pend;

    assign o_hit  = r_valid && (r_tag == i_tag) && !i_flush;
    assign o_data = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag        <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            if (i_load) begin
                r_tag   <= i_tag;
                r_data  <= i_load_data;
                r_valid <= 1'b1;
            end
            if (i_merge) begin
                r_data <= lane_merge(r_data, i_off, i_wbyte);
            end
            if (i_flush && i_idle) begin
                r_valid <= 1'b0;
            end
            if (i_flush && !i_idle && !i_end) begin
                r_flush_pend <= 1'b1;
            end
            if (i_end && (r_flush_pend || i_flush)) begin
                r_valid      <= 1'b0;
                r_flush_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/qspi_mem_bridge.sv
// rtl/qspi_mem_bridge.sv - 8-bit CPU byte access to 32-bit QSPI word transactions
// Purpose: byte reads served from a one-word line buffer or a QSPI word read;
//   byte writes read-modify-write the word and write it through.
// Ports: clk/rst (async, active-high); CPU side i_req/i_we/i_addr/i_wdata/i_flush,
//   o_rdata/o_ready; controller side o_q_start/o_q_write/o_q_address/o_q_data_in,
//   i_q_busy/i_q_data_out.
import jrb8_mem_pkg::*;

module qspi_mem_bridge #(
    parameter int          ADDR_W    = 16,
    parameter logic [23:0] BASE_ADDR = 24'h000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    input  logic              i_flush,
    output logic [7:0]        o_rdata,
    output logic              o_ready,
    output logic              o_q_start,
    output logic              o_q_write,
    output logic [23:0]       o_q_address,
    output logic [31:0]       o_q_data_in,
    input  logic              i_q_busy,
    input  logic [31:0]       i_q_data_out
);

    localparam int OFF_W = $clog2(QSPI_WORD_BYTES);
    localparam int TAG_W = ADDR_W - OFF_W;

    bridge_state_t r_state, w_next;

    logic              r_seen_busy;
    logic              r_q_write;
    logic [23:0]       r_q_address;
    logic [31:0]       r_q_data_in;
    logic [7:0]        r_rdata;

    logic [TAG_W-1:0]  w_tag;
    logic [1:0]        w_off;
    logic [23:0]       w_word_addr;
    logic              w_hit;
    logic [31:0]       w_line;
    logic              w_done;
    logic              w_load;
    logic              w_merge;

    assign w_tag       = i_addr[ADDR_W-1:OFF_W];
    assign w_off       = i_addr[OFF_W-1:0];
    assign w_word_addr = BASE_ADDR + 24'({w_tag, 2'b00});
    // Busy must have risen after our start before its low level means "finished".
    assign w_done      = r_seen_busy && !i_q_busy;

    assign o_q_write   = r_q_write;
    assign o_q_address = r_q_address;
    assign o_q_data_in = r_q_data_in;

    qspi_line_buffer #(.TAG_W(TAG_W)) u_line (
        .clk         (clk),
        .rst         (rst),
        .i_tag       (w_tag),
        .i_flush     (i_flush),
        .i_idle      (r_state == S_IDLE),
        .i_end       (r_state == S_RESPOND),
        .i_load      (w_load),
        .i_load_data (i_q_data_out),
        .i_merge     (w_merge),
        .i_off       (w_off),
        .i_wbyte     (i_wdata),
        .o_hit       (w_hit),
        .o_data      (w_line)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        o_q_start = 1'b0;
        o_ready   = 1'b0;
        o_rdata   = r_rdata;
        w_load    = 1'b0;
        w_merge   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_req) begin
                    if (w_hit) w_next = i_we ? S_MERGE : S_RESPOND;
                    else       w_next = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: begin
                o_q_start = 1'b1;
                w_next    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (w_done) begin
                    w_load = 1'b1;
                    w_next = i_we ? S_MERGE : S_RESPOND;
                end
            end
            S_MERGE: begin
                w_merge = 1'b1;
                w_next  = S_WR_ISSUE;
            end
            S_WR_ISSUE: begin
                o_q_start = 1'b1;
                w_next    = S_WR_WAIT;
            end
            S_WR_WAIT: begin
                if (w_done) w_next = S_RESPOND;
            end
            S_RESPOND: begin
                o_ready = 1'b1;
                if (!i_we) o_rdata = lane_sel(w_line, w_off);
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen_busy <= 1'b0;
            r_q_write   <= 1'b0;
            r_q_address <= '0;
            r_q_data_in <= '0;
            r_rdata     <= '0;
        end else begin
            if (o_q_start) begin
                r_seen_busy <= 1'b0;
            end else if ((r_state == S_RD_WAIT || r_state == S_WR_WAIT) && i_q_busy) begin
                r_seen_busy <= 1'b1;
            end
            if (r_state == S_IDLE && i_req) begin
                r_q_address <= w_word_addr;
                r_q_write   <= i_we && w_hit;
            end
            if (r_state == S_MERGE) begin
                r_q_write   <= 1'b1;
                r_q_data_in <= lane_merge(w_line, w_off, i_wdata);
            end
            if (r_state == S_RESPOND && !i_we) begin
                r_rdata <= o_rdata;
            end
        end
    end

endmodule

// File: tb/tb_qspi_mem_bridge.sv
// tb/tb_qspi_mem_bridge.sv - directed bench for qspi_mem_bridge with a behavioural QSPI memory
module tb_qspi_mem_bridge;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, flush;
    logic [15:0] addr;
    logic [7:0]  wdata, rdata;
    logic        ready, q_start, q_write, q_busy;
    logic [23:0] q_address;
    logic [31:0] q_data_in, q_data_out;

    qspi_mem_bridge #(.ADDR_W(16), .BASE_ADDR(24'h000000)) dut (
        .clk(clk), .rst(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
        .i_flush(flush), .o_rdata(rdata), .o_ready(ready), .o_q_start(q_start),
        .o_q_write(q_write), .o_q_address(q_address), .o_q_data_in(q_data_in),
        .i_q_busy(q_busy), .i_q_data_out(q_data_out)
    );

    logic        rst2, req2, we2, flush2, busy2;
    logic [15:0] addr2;
    logic [7:0]  wdata2, rdata2;
    logic        ready2, q_start2, q_write2;
    logic [23:0] q_address2;
    logic [31:0] q_data_in2, q_data_out2;

    qspi_mem_bridge #(.ADDR_W(16), .BASE_ADDR(24'hFFFFFC)) dut2 (
        .clk(clk), .rst(rst2), .i_req(req2), .i_we(we2), .i_addr(addr2), .i_wdata(wdata2),
        .i_flush(flush2), .o_rdata(rdata2), .o_ready(ready2), .o_q_start(q_start2),
        .o_q_write(q_write2), .o_q_address(q_address2), .o_q_data_in(q_data_in2),
        .i_q_busy(busy2), .i_q_data_out(q_data_out2)
    );

    // Behavioural controller + memory: busy for 3 cycles after each start.
    logic [31:0] mem [0:1023];
    int          busy_left;
    logic [23:0] m_addr;
    logic        m_wr;
    logic [31:0] m_data;
    int          n_start, n_overlap;
    logic [23:0] last_addr;
    logic        last_wr;
    logic [31:0] last_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q_busy      <= 1'b0;
            q_data_out  <= '0;
            busy_left   <= 0;
            mem[10'h040] <= 32'hA1B2C3D4;
            mem[10'h081] <= 32'h00000000;
            mem[10'h0C0] <= 32'h12345678;
        end else if (q_start) begin
            if (q_busy) n_overlap <= n_overlap + 1;
            n_start   <= n_start + 1;
            last_addr <= q_address;
            last_wr   <= q_write;
            last_data <= q_data_in;
            m_addr    <= q_address;
            m_wr      <= q_write;
            m_data    <= q_data_in;
            q_busy    <= 1'b1;
            busy_left <= 3;
        end else if (q_busy) begin
            if (busy_left == 1) begin
                q_busy <= 1'b0;
                if (m_wr) mem[m_addr[11:2]] <= m_data;
                else      q_data_out <= mem[m_addr[11:2]];
            end
            busy_left <= busy_left - 1;
        end
    end

    int total, bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access; flush is high in the cycle numbered fl_at (0 = with req, -1 = never).
    task automatic do_req(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input int fl_at, output logic [7:0] rd, output int cyc);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; flush = (fl_at == 0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            flush = (cyc == fl_at);
        end while (!ready && cyc < 200);
        rd = rdata;
        chk("ready_seen", {31'b0, ready}, 32'd1);
        @(negedge clk);
        req = 1'b0; flush = 1'b0;
    endtask

    logic [7:0] rd;
    int         cyc, s0;

    initial begin
        n_start = 0; n_overlap = 0; total = 0; bad = 0;
        rst = 1'b1; rst2 = 1'b1; req = 0; we = 0; flush = 0; addr = '0; wdata = '0;
        req2 = 0; we2 = 0; flush2 = 0; busy2 = 0; addr2 = '0; wdata2 = '0; q_data_out2 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_start", {31'b0, q_start}, 32'd0);
        chk("rst_write", {31'b0, q_write}, 32'd0);
        chk("rst_addr", {8'b0, q_address}, 32'd0);
        chk("rst_din", q_data_in, 32'd0);
        chk("rst_rdata", {24'b0, rdata}, 32'd0);
        @(negedge clk);
        rst = 1'b0; rst2 = 1'b0;

        // read miss
        s0 = n_start;
        do_req(1'b0, 16'h0102, 8'h00, -1, rd, cyc);
        chk("rmiss_rdata", {24'b0, rd}, 32'h0000_00C3);
        chk("rmiss_starts", n_start - s0, 32'd1);
        chk("rmiss_addr", {8'b0, last_addr}, 32'h0000_0100);
        chk("rmiss_wr", {31'b0, last_wr}, 32'd0);

        // read hit
        s0 = n_start;
        do_req(1'b0, 16'h0103, 8'h00, -1, rd, cyc);
        chk("rhit_rdata", {24'b0, rd}, 32'h0000_00D4);
        chk("rhit_lat", cyc, 32'd1);
        chk("rhit_starts", n_start - s0, 32'd0);

        // write hit, then read back the new byte from the line
        s0 = n_start;
        do_req(1'b1, 16'h0100, 8'h55, -1, rd, cyc);
        chk("whit_starts", n_start - s0, 32'd1);
        chk("whit_wr", {31'b0, last_wr}, 32'd1);
        chk("whit_data", last_data, 32'h55B2C3D4);
        chk("whit_mem", mem[10'h040], 32'h55B2C3D4);
        s0 = n_start;
        do_req(1'b0, 16'h0100, 8'h00, -1, rd, cyc);
        chk("whit_rd", {24'b0, rd}, 32'h0000_0055);
        chk("whit_rd_lat", cyc, 32'd1);
        chk("whit_rd_starts", n_start - s0, 32'd0);

        // write miss: read then write
        s0 = n_start;
        do_req(1'b1, 16'h0205, 8'hEE, -1, rd, cyc);
        chk("wmiss_starts", n_start - s0, 32'd2);
        chk("wmiss_data", last_data, 32'h00EE0000);
        chk("wmiss_addr", {8'b0, last_addr}, 32'h0000_0204);
        chk("wmiss_wr", {31'b0, last_wr}, 32'd1);

        // flush with req on a cached word forces a miss
        s0 = n_start;
        do_req(1'b0, 16'h0205, 8'h00, 0, rd, cyc);
        chk("flush0_starts", n_start - s0, 32'd1);
        chk("flush0_rdata", {24'b0, rd}, 32'h0000_00EE);

        // flush mid-transaction: access completes, line invalid afterwards
        s0 = n_start;
        do_req(1'b0, 16'h0100, 8'h00, 3, rd, cyc);
        chk("flushm_rdata", {24'b0, rd}, 32'h0000_0055);
        s0 = n_start;
        do_req(1'b0, 16'h0101, 8'h00, -1, rd, cyc);
        chk("flushm_next_starts", n_start - s0, 32'd1);
        chk("flushm_next_rdata", {24'b0, rd}, 32'h0000_00B2);

        // reset during RD_WAIT
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 16'h0300;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!q_start && cyc < 50);
        chk("rstw_start_seen", {31'b0, q_start}, 32'd1);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rstw_ready", {31'b0, ready}, 32'd0);
        chk("rstw_start", {31'b0, q_start}, 32'd0);
        chk("rstw_addr", {8'b0, q_address}, 32'd0);
        chk("rstw_write", {31'b0, q_write}, 32'd0);
        chk("rstw_din", q_data_in, 32'd0);
        chk("rstw_rdata", {24'b0, rdata}, 32'd0);
        @(posedge clk); #1;
        chk("rstw_ready_hold", {31'b0, ready}, 32'd0);
        @(negedge clk);
        req = 1'b0; rst = 1'b0;
        s0 = n_start;
        do_req(1'b0, 16'h0300, 8'h00, -1, rd, cyc);
        chk("rstw_next_starts", n_start - s0, 32'd1);
        chk("rstw_next_rdata", {24'b0, rd}, 32'h0000_0012);

        chk("no_start_while_busy", n_overlap, 32'd0);

        // address wrap with BASE_ADDR near the top of the 24-bit space
        @(negedge clk);
        req2 = 1'b1; addr2 = 16'h0004;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!q_start2 && cyc < 20);
        chk("wrap_start_seen", {31'b0, q_start2}, 32'd1);
        chk("wrap_addr", {8'b0, q_address2}, 32'h0000_0000);
        chk("wrap_wr", {31'b0, q_write2}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
